// File: rtl/serial_deser_pkg.sv
// Shared constants and width helpers for the serial deserializer.
package serial_deser_pkg;

    localparam int unsigned ORDER_LSB_FIRST = 0;
    localparam int unsigned ORDER_MSB_FIRST = 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // The length field must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return clog2(width + 1);
    endfunction

endpackage

// File: rtl/ser_out_buf.sv
// One-entry output holding register with valid/ready handshake and overrun pulse.
module ser_out_buf
    import serial_deser_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic [CW-1:0]    len,
    input  logic             ready,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    out_len,
    output logic             valid,
    output logic             overrun
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    len_q, len_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             free;

    always_comb begin
        free      = !valid_q || ready;
        out_d     = out_q;
        len_d     = len_q;
        valid_d   = valid_q;
        overrun_d = load && !free;
        if (load && free) begin
            out_d   = word;
            len_d   = len;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            len_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            len_q     <= len_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out     = out_q;
    assign out_len = len_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer: shifter and bit counter feeding a one-entry output buffer.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned MSB_FIRST     = ORDER_LSB_FIRST,
    parameter int unsigned FLUSH_PARTIAL = 0,
    localparam int unsigned CW           = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             in,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    out_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    logic [WIDTH-1:0] sr_q, sr_d, sr_shift, load_word;
    logic [CW-1:0]    cnt_q, cnt_d, load_len;
    logic [0:0]       state_q, state_d;
    logic             load;

    always_comb begin
        if (MSB_FIRST == ORDER_MSB_FIRST) begin
            sr_shift = {sr_q[WIDTH-2:0], in};
        end else begin
            sr_shift = {in, sr_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        load_word = sr_shift;
        load_len  = CW'(WIDTH);
        if (clr) begin
            // Abort wins over a frame that would complete this cycle.
            sr_d  = '0;
            cnt_d = '0;
        end else if (we) begin
            if (cnt_q == CW'(WIDTH - 1)) begin
                load  = 1'b1;
                sr_d  = '0;
                cnt_d = '0;
            end else begin
                sr_d  = sr_shift;
                cnt_d = cnt_q + 1'b1;
            end
        end else if (FLUSH_PARTIAL != 0 && cnt_q != '0) begin
            load      = 1'b1;
            load_word = sr_q;
            load_len  = cnt_q;
            sr_d      = '0;
            cnt_d     = '0;
        end
        state_d = (cnt_d != '0) ? ST_SHIFT : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);

    ser_out_buf #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .word    (load_word),
        .len     (load_len),
        .ready   (out_ready),
        .out     (out),
        .out_len (out_len),
        .valid   (out_valid),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_serial_deser.sv
// Scoreboard bench for serial_deser: three WIDTH=8 variants (LSB-first, MSB-first, LSB-first flush).
module tb_serial_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] we, bin, clr, rdy;
    logic [2:0] valid_w, busy_w, ovr_w;
    logic [7:0] out_w [3];
    logic [3:0] len_w [3];

    logic [11:0] q0[$], q1[$], q2[$];
    int checks = 0;
    int errors = 0;
    int ovr_cnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    serial_deser #(.WIDTH(8), .MSB_FIRST(0), .FLUSH_PARTIAL(0)) u_lsb (
        .clk(clk), .rst(rst), .we(we[0]), .in(bin[0]), .clr(clr[0]),
        .out(out_w[0]), .out_len(len_w[0]), .out_valid(valid_w[0]),
        .out_ready(rdy[0]), .busy(busy_w[0]), .overrun(ovr_w[0])
    );

    serial_deser #(.WIDTH(8), .MSB_FIRST(1), .FLUSH_PARTIAL(0)) u_msb (
        .clk(clk), .rst(rst), .we(we[1]), .in(bin[1]), .clr(clr[1]),
        .out(out_w[1]), .out_len(len_w[1]), .out_valid(valid_w[1]),
        .out_ready(rdy[1]), .busy(busy_w[1]), .overrun(ovr_w[1])
    );

    serial_deser #(.WIDTH(8), .MSB_FIRST(0), .FLUSH_PARTIAL(1)) u_flush (
        .clk(clk), .rst(rst), .we(we[2]), .in(bin[2]), .clr(clr[2]),
        .out(out_w[2]), .out_len(len_w[2]), .out_valid(valid_w[2]),
        .out_ready(rdy[2]), .busy(busy_w[2]), .overrun(ovr_w[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] word, input logic [3:0] len);
        case (k)
            0: q0.push_back({len, word});
            1: q1.push_back({len, word});
            default: q2.push_back({len, word});
        endcase
    endtask

    task automatic pop_check(input int k);
        logic [11:0] e;
        int          sz;
        case (k)
            0: sz = q0.size();
            1: sz = q1.size();
            default: sz = q2.size();
        endcase
        checks++;
        if (sz == 0) begin
            errors++;
            $display("FAIL sb%0d_unexpected actual=%0h required=none", k, out_w[k]);
        end else begin
            case (k)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            if ({len_w[k], out_w[k]} !== e) begin
                errors++;
                $display("FAIL sb%0d_word actual=%0h/%0d required=%0h/%0d",
                         k, out_w[k], len_w[k], e[7:0], e[11:8]);
            end
        end
    endtask

    // Monitor: a word is consumed on each cycle where valid && ready is seen.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (valid_w[k] && rdy[k]) pop_check(k);
                if (ovr_w[k]) ovr_cnt[k]++;
            end
        end
    end

    // Bits are sent seq[n-1] first.
    task automatic send_bits(input int k, input logic [15:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            we[k]  = 1'b1;
            bin[k] = seq[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int k, input int n);
        we[k]  = 1'b0;
        bin[k] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        we  = '0;
        bin = '0;
        clr = '0;
        rdy = 3'b111;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d_out", k), 32'(out_w[k]), 32'h0);
            chk($sformatf("rst%0d_len", k), 32'(len_w[k]), 32'h0);
            chk($sformatf("rst%0d_valid", k), 32'(valid_w[k]), 32'h0);
            chk($sformatf("rst%0d_busy", k), 32'(busy_w[k]), 32'h0);
            chk($sformatf("rst%0d_ovr", k), 32'(ovr_w[k]), 32'h0);
        end
        rst = 1'b0;

        // LSB-first 1,0,1,0,0,1,0,1 -> 0xA5
        push(0, 8'hA5, 4'd8);
        send_bits(0, 16'b10100101, 8);
        chk("lsb_out", 32'(out_w[0]), 32'hA5);
        chk("lsb_len", 32'(len_w[0]), 32'd8);
        chk("lsb_valid", 32'(valid_w[0]), 32'd1);
        chk("lsb_busy", 32'(busy_w[0]), 32'd0);
        idle(0, 1);
        chk("lsb_consumed", 32'(valid_w[0]), 32'd0);

        // MSB-first 0xA5, then contiguous 0x3C, 0xC3
        push(1, 8'hA5, 4'd8);
        push(1, 8'h3C, 4'd8);
        push(1, 8'hC3, 4'd8);
        send_bits(1, 16'b10100101, 8);
        chk("msb_out", 32'(out_w[1]), 32'hA5);
        send_bits(1, 16'b00111100, 8);
        chk("msb_3c", 32'(out_w[1]), 32'h3C);
        send_bits(1, 16'b11000011, 8);
        chk("msb_c3", 32'(out_w[1]), 32'hC3);
        chk("msb_c3_valid", 32'(valid_w[1]), 32'd1);
        chk("msb_c3_ovr", 32'(ovr_w[1]), 32'd0);
        idle(1, 1);

        // Backpressure: 0x11 held, 0x22 dropped with overrun
        rdy[0] = 1'b0;
        push(0, 8'h11, 4'd8);
        send_bits(0, 16'b10001000, 8);
        chk("bp_first", 32'(out_w[0]), 32'h11);
        send_bits(0, 16'b01000100, 8);
        chk("bp_hold", 32'(out_w[0]), 32'h11);
        chk("bp_ovr", 32'(ovr_w[0]), 32'd1);
        idle(0, 1);
        chk("bp_ovr_pulse", 32'(ovr_w[0]), 32'd0);
        chk("bp_valid", 32'(valid_w[0]), 32'd1);
        rdy[0] = 1'b1;
        idle(0, 1);
        chk("bp_drop", 32'(valid_w[0]), 32'd0);

        // Same-cycle consume and deliver on u_msb
        rdy[1] = 1'b0;
        push(1, 8'h3C, 4'd8);
        send_bits(1, 16'b00111100, 8);
        idle(1, 2);
        chk("sc_hold", 32'(out_w[1]), 32'h3C);
        push(1, 8'hC3, 4'd8);
        send_bits(1, 16'b1100001, 7);
        rdy[1] = 1'b1;
        send_bits(1, 16'b1, 1);
        chk("sc_out", 32'(out_w[1]), 32'hC3);
        chk("sc_valid", 32'(valid_w[1]), 32'd1);
        chk("sc_ovr", 32'(ovr_w[1]), 32'd0);
        idle(1, 1);
        chk("sc_drained", 32'(valid_w[1]), 32'd0);

        // Partial flush: 1,1,0 -> 0x60 len 3
        push(2, 8'h60, 4'd3);
        send_bits(2, 16'b110, 3);
        chk("fl_busy", 32'(busy_w[2]), 32'd1);
        idle(2, 1);
        chk("fl_out", 32'(out_w[2]), 32'h60);
        chk("fl_len", 32'(len_w[2]), 32'd3);
        chk("fl_valid", 32'(valid_w[2]), 32'd1);
        chk("fl_busy_after", 32'(busy_w[2]), 32'd0);
        idle(2, 1);

        // No flush: partial retained, 5 more bits complete 0xAB
        send_bits(0, 16'b110, 3);
        idle(0, 2);
        chk("nf_busy", 32'(busy_w[0]), 32'd1);
        chk("nf_valid", 32'(valid_w[0]), 32'd0);
        push(0, 8'hAB, 4'd8);
        send_bits(0, 16'b10101, 5);
        chk("nf_out", 32'(out_w[0]), 32'hAB);
        chk("nf_len", 32'(len_w[0]), 32'd8);
        idle(0, 1);

        // clr after 4 bits with a word parked in the output
        rdy[0] = 1'b0;
        push(0, 8'h96, 4'd8);
        send_bits(0, 16'b01101001, 8);
        send_bits(0, 16'b1111, 4);
        chk("clr_busy_pre", 32'(busy_w[0]), 32'd1);
        clr[0] = 1'b1;
        we[0]  = 1'b1;
        bin[0] = 1'b1;
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        chk("clr_busy", 32'(busy_w[0]), 32'd0);
        chk("clr_valid", 32'(valid_w[0]), 32'd1);
        chk("clr_out", 32'(out_w[0]), 32'h96);
        rdy[0] = 1'b1;
        push(0, 8'h3C, 4'd8);
        send_bits(0, 16'b00111100, 8);
        chk("clr_clean", 32'(out_w[0]), 32'h3C);
        idle(0, 1);

        // Reset mid-frame with a word held
        rdy[0] = 1'b0;
        send_bits(0, 16'b11111111, 8);
        send_bits(0, 16'b101, 3);
        chk("mr_valid_pre", 32'(valid_w[0]), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        we[0] = 1'b0;
        chk("mr_out", 32'(out_w[0]), 32'h0);
        chk("mr_len", 32'(len_w[0]), 32'h0);
        chk("mr_valid", 32'(valid_w[0]), 32'h0);
        chk("mr_busy", 32'(busy_w[0]), 32'h0);
        chk("mr_ovr", 32'(ovr_w[0]), 32'h0);
        rdy[0] = 1'b1;
        idle(0, 2);

        chk("sb0_empty", 32'(q0.size()), 32'd0);
        chk("sb1_empty", 32'(q1.size()), 32'd0);
        chk("sb2_empty", 32'(q2.size()), 32'd0);
        chk("ovr0_count", 32'(ovr_cnt[0]), 32'd1);
        chk("ovr1_count", 32'(ovr_cnt[1]), 32'd0);
        chk("ovr2_count", 32'(ovr_cnt[2]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
